// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage of the 24-bit CPU.
// Owns the program counter, presents it to the combinational instruction
// memory and latches the returned word into the IF/ID pipeline register.
// Handles stall, flush, branch/jump redirect and halt-opcode detection.
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W      = 24,
  parameter int unsigned       INSTR_W     = 24,
  parameter logic [ADDR_W-1:0] RESET_PC    = 24'h000000,
  parameter logic [4:0]        HALT_OPCODE = 5'b11111
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  input  logic               JumpTaken,
  input  logic [ADDR_W-1:0]  JumpTarget,
  output logic [ADDR_W-1:0]  PC,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [INSTR_W-1:0] IF_ID_Instruction,
  output logic [ADDR_W-1:0]  IF_ID_PC,
  output logic [ADDR_W-1:0]  IF_ID_PCPlus1,
  output logic               IF_ID_Valid,
  output logic               Halted,
  output logic [15:0]        FetchCount
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t              state_r;
  logic                redirect_s;
  logic [ADDR_W-1:0]   redirect_pc_s;
  logic [ADDR_W-1:0]   pc_plus1_s;
  logic                is_halt_s;
  logic [15:0]         fetch_count_next_s;

  // Redirect selection (jump beats branch), PC increment, halt decode, saturating count
  always_comb begin
    redirect_s = JumpTaken | BranchTaken;
    if (JumpTaken) begin
      redirect_pc_s = JumpTarget;
    end else begin
      redirect_pc_s = BranchTarget;
    end
    pc_plus1_s = PC + {{(ADDR_W-1){1'b0}}, 1'b1};
    is_halt_s  = (Instruction[INSTR_W-1 -: 5] == HALT_OPCODE);
    if (FetchCount == 16'hFFFF) begin
      fetch_count_next_s = FetchCount;
    end else begin
      fetch_count_next_s = FetchCount + 16'd1;
    end
  end

  // Fetch FSM: PC, IF/ID register, halt flag and fetch counter
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r           <= RUN;
      PC                <= RESET_PC;
      IF_ID_Instruction <= {INSTR_W{1'b0}};
      IF_ID_PC          <= {ADDR_W{1'b0}};
      IF_ID_PCPlus1     <= {ADDR_W{1'b0}};
      IF_ID_Valid       <= 1'b0;
      Halted            <= 1'b0;
      FetchCount        <= 16'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (redirect_s) begin
            // Redirect wins over stall/flush so a mispredict never loses the target
            PC          <= redirect_pc_s;
            IF_ID_Valid <= 1'b0;
          end else if (Flush) begin
            IF_ID_Valid <= 1'b0;
          end else if (Stall) begin
            IF_ID_Valid <= IF_ID_Valid;
          end else begin
            IF_ID_Instruction <= Instruction;
            IF_ID_PC          <= PC;
            IF_ID_PCPlus1     <= pc_plus1_s;
            IF_ID_Valid       <= 1'b1;
            FetchCount        <= fetch_count_next_s;
            if (is_halt_s) begin
              // Halt word itself is delivered; PC parks on it
              state_r <= HALTED;
              Halted  <= 1'b1;
            end else begin
              PC <= pc_plus1_s;
            end
          end
        end
        HALTED: begin
          if (redirect_s) begin
            // Halt was speculative behind an older branch: resume at target
            PC          <= redirect_pc_s;
            IF_ID_Valid <= 1'b0;
            state_r     <= RUN;
            Halted      <= 1'b0;
          end else if (Stall && !Flush) begin
            IF_ID_Valid <= IF_ID_Valid;
          end else begin
            IF_ID_Valid <= 1'b0;
          end
        end
        default: begin
          state_r     <= RUN;
          Halted      <= 1'b0;
          IF_ID_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus random
// stimulus, with a reference model feeding a scoreboard queue that a
// separate monitor drains after every clock edge.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump_taken = 1'b0;
  logic [23:0] branch_target = 24'h0;
  logic [23:0] jump_target = 24'h0;
  logic [23:0] pc;
  logic [23:0] instruction;
  logic [23:0] if_id_instruction;
  logic [23:0] if_id_pc;
  logic [23:0] if_id_pcplus1;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int checks = 0;
  int failures = 0;

  instruction_fetch_unit dut (
    .Clock(clock), .Reset(reset), .Stall(stall), .Flush(flush),
    .BranchTaken(branch_taken), .BranchTarget(branch_target),
    .JumpTaken(jump_taken), .JumpTarget(jump_target),
    .PC(pc), .Instruction(instruction),
    .IF_ID_Instruction(if_id_instruction), .IF_ID_PC(if_id_pc),
    .IF_ID_PCPlus1(if_id_pcplus1), .IF_ID_Valid(if_id_valid),
    .Halted(halted), .FetchCount(fetch_count)
  );

  always #5 clock = ~clock;

  // Instruction memory: explicit overrides, otherwise a hashed non-halt word
  logic [23:0] mem_over [logic [23:0]];
  int          mem_gen = 0;

  function automatic logic [23:0] mem_word(input logic [23:0] a);
    logic [23:0] w;
    if (mem_over.exists(a)) begin
      w = mem_over[a];
    end else begin
      w = (a * 24'd40503) ^ 24'h5A5A5A;
      if (w[23:19] == 5'h1F) w[23] = 1'b0;
    end
    return w;
  endfunction

  always @(pc or mem_gen) instruction = mem_word(pc);

  // Reference model state
  typedef struct {
    logic [23:0] pc;
    logic [23:0] instr;
    logic [23:0] ipc;
    logic [23:0] ipc1;
    logic        valid;
    logic        halted;
    logic [15:0] count;
  } snap_t;

  snap_t m;
  snap_t sbq[$];

  task automatic model_reset();
    m.pc = 24'h0; m.instr = 24'h0; m.ipc = 24'h0; m.ipc1 = 24'h0;
    m.valid = 1'b0; m.halted = 1'b0; m.count = 16'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_pc"}, {8'h0, pc}, 32'h0);
    chk({name, "_instr"}, {8'h0, if_id_instruction}, 32'h0);
    chk({name, "_ifpc"}, {8'h0, if_id_pc}, 32'h0);
    chk({name, "_ifpc1"}, {8'h0, if_id_pcplus1}, 32'h0);
    chk({name, "_valid"}, {31'h0, if_id_valid}, 32'h0);
    chk({name, "_halted"}, {31'h0, halted}, 32'h0);
    chk({name, "_count"}, {16'h0, fetch_count}, 32'h0);
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue expectation.
  // Called at a negedge (or just after reset release); returns at the next negedge.
  task automatic step(input logic st, input logic fl, input logic br,
                      input logic [23:0] bt, input logic jp, input logic [23:0] jt);
    logic [23:0] w;
    stall = st; flush = fl; branch_taken = br; branch_target = bt;
    jump_taken = jp; jump_target = jt;
    if (jp || br) begin
      m.pc = jp ? jt : bt;
      m.valid = 1'b0;
      m.halted = 1'b0;
    end else if (m.halted) begin
      if (fl || !st) m.valid = 1'b0;
    end else if (fl) begin
      m.valid = 1'b0;
    end else if (!st) begin
      w = mem_word(m.pc);
      m.instr = w;
      m.ipc = m.pc;
      m.ipc1 = m.pc + 24'd1;
      m.valid = 1'b1;
      if (m.count != 16'hFFFF) m.count = m.count + 16'd1;
      if (w[23:19] == 5'h1F) m.halted = 1'b1;
      else m.pc = m.pc + 24'd1;
    end
    sbq.push_back(m);
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
  endtask

  // Assert reset at a negedge, check values, release at the following negedge
  task automatic do_reset(input string name);
    reset = 1'b1;
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
    #1;
    check_reset(name);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: after each edge compare DUT outputs with the queued expectation
  initial begin
    snap_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (pc !== e.pc || if_id_instruction !== e.instr || if_id_pc !== e.ipc ||
            if_id_pcplus1 !== e.ipc1 || if_id_valid !== e.valid ||
            halted !== e.halted || fetch_count !== e.count) begin
          failures++;
          $display("FAIL scoreboard t=%0t: got pc=%h ins=%h ipc=%h ipc1=%h v=%b h=%b cnt=%0d expected pc=%h ins=%h ipc=%h ipc1=%h v=%b h=%b cnt=%0d",
                   $time, pc, if_id_instruction, if_id_pc, if_id_pcplus1, if_id_valid, halted, fetch_count,
                   e.pc, e.instr, e.ipc, e.ipc1, e.valid, e.halted, e.count);
        end
      end
    end
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) mem_over[24'(i)] = 24'(i + 1);
    mem_gen++;
    #1 reset = 1'b1;
    #2 check_reset("reset");
    @(negedge clock);
    reset = 1'b0;

    // Sequential fetch from reset
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("seq_ifpc", {8'h0, if_id_pc}, 32'(i));
      chk("seq_instr", {8'h0, if_id_instruction}, 32'(i + 1));
      chk("seq_valid", {31'h0, if_id_valid}, 32'h1);
    end

    // Stall for three cycles with IF_ID_PC = 2
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
      chk("stall_pc", {8'h0, pc}, 32'h3);
      chk("stall_ifpc", {8'h0, if_id_pc}, 32'h2);
    end
    idle();
    chk("after_stall_ifpc", {8'h0, if_id_pc}, 32'h3);
    chk("count4", {16'h0, fetch_count}, 32'd4);

    // Jump + branch + stall on one edge: jump wins
    step(1'b1, 1'b0, 1'b1, 24'h000100, 1'b1, 24'h000200);
    chk("redir_pc", {8'h0, pc}, 32'h200);
    chk("redir_bubble", {31'h0, if_id_valid}, 32'h0);
    idle();
    chk("redir_ifpc", {8'h0, if_id_pc}, 32'h200);
    chk("redir_valid", {31'h0, if_id_valid}, 32'h1);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'hFFFFFF);
    idle();
    chk("wrap_ifpc", {8'h0, if_id_pc}, 32'hFFFFFF);
    chk("wrap_ifpc1", {8'h0, if_id_pcplus1}, 32'h0);
    chk("wrap_pc", {8'h0, pc}, 32'h0);

    // Halt word at address 5, then jump out
    mem_over[24'h5] = 24'hF80000;
    mem_gen++;
    do_reset("reset2");
    for (int i = 0; i < 6; i++) idle();
    chk("halt_instr", {8'h0, if_id_instruction}, 32'hF80000);
    chk("halt_valid", {31'h0, if_id_valid}, 32'h1);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    chk("halt_pc", {8'h0, pc}, 32'h5);
    idle();
    chk("halted_bubble", {31'h0, if_id_valid}, 32'h0);
    chk("halted_pc", {8'h0, pc}, 32'h5);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h000010);
    chk("unhalt_flag", {31'h0, halted}, 32'h0);
    chk("unhalt_pc", {8'h0, pc}, 32'h10);
    idle();
    chk("resume_ifpc", {8'h0, if_id_pc}, 32'h10);

    // Async reset mid-cycle while halted with FetchCount = 7
    mem_over.delete(24'h5);
    mem_over[24'h6] = 24'hF80000;
    mem_gen++;
    do_reset("reset3");
    for (int i = 0; i < 8; i++) idle();
    chk("pre_async_count", {16'h0, fetch_count}, 32'd7);
    chk("pre_async_halted", {31'h0, halted}, 32'h1);
    #2 reset = 1'b1;
    #1 check_reset("async_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // Random phase with a few halt words in the low address range
    mem_over.delete(24'h6);
    for (int i = 0; i < 3; i++) mem_over[24'($urandom_range(8, 63))] = {5'h1F, 19'($urandom)};
    mem_gen++;
    do_reset("reset4");
    for (int i = 0; i < 1500; i++) begin
      logic        st, fl, br, jp;
      logic [23:0] bt, jt;
      st = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 99) < 10);
      br = ($urandom_range(0, 99) < 8);
      jp = ($urandom_range(0, 99) < 5);
      bt = 24'($urandom_range(0, 63));
      jt = ($urandom_range(0, 9) == 0) ? 24'hFFFFFE : 24'($urandom_range(0, 63));
      step(st, fl, br, bt, jp, jt);
    end

    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
